rotating_priority_resolver: RTL

ROTATING_PRIORITY_RESOLVER -- requirements
Module: rotating_priority_resolver

---
 rtl/rotating_priority_resolver_pkg.sv | 18 +
 rtl/rotating_priority_resolver_circ_priority_enc.sv | 38 +++
 rtl/rotating_priority_resolver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rotating_priority_resolver_pkg.sv
// Shared types and helpers for the rotating priority resolver.
// Holds the acknowledge FSM state encoding and a constant ceil-log2.
package rotating_priority_resolver_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    // Index width for an N-entry vector; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/rotating_priority_resolver_circ_priority_enc.sv
// Circular find-first: the entry just after pointer lp has top priority, descending around the ring.
// Combinational; rank is the distance from the top-priority slot (0 = highest).
module circ_priority_enc
    import rotating_priority_resolver_pkg::*;
#(
    parameter int N    = 8,
    parameter int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] lp,
    output logic            found,
    output logic [ID_W-1:0] idx,
    output logic [ID_W-1:0] rank
);

    logic [ID_W-1:0] sh;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;

    // Rotate so the highest-priority line lands at bit 0; lp=N-1 means no rotation.
    assign sh  = (lp == ID_W'(N - 1)) ? '0 : lp + 1'b1;
    assign dbl = {req, req};
    assign rot = N'(dbl >> sh);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        rank  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                rank  = ID_W'(k);
                idx   = (int'(sh) + k >= N) ? ID_W'(int'(sh) + k - N) : ID_W'(int'(sh) + k);
            end
        end
    end

endmodule

// File: rtl/rotating_priority_resolver.sv
// 8259-style fully nested interrupt resolver with rotating priority and two-pulse acknowledge.
// int_o and acknowledge outputs are registered; EOI commands act on the pre-cycle isr.
module rotating_priority_resolver
    import rotating_priority_resolver_pkg::*;
#(
    parameter int N = 8,
    localparam int ID_W = clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    irr,
    input  logic [N-1:0]    imr,
    input  logic            inta_pulse,
    input  logic            eoi,
    input  logic            seoi,
    input  logic [ID_W-1:0] seoi_id,
    input  logic            aeoi_mode,
    input  logic            rotate_mode,
    output logic            int_o,
    output logic [N-1:0]    isr,
    output logic [N-1:0]    irr_clr,
    output logic            vec_valid,
    output logic [ID_W-1:0] vec_id
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    isr_q, isr_d;
    logic [N-1:0]    irr_clr_q, irr_clr_d;
    logic [ID_W-1:0] lp_q, lp_d;
    logic [ID_W-1:0] cur_id_q, cur_id_d;
    logic [ID_W-1:0] vec_id_q, vec_id_d;
    logic            spurious_q, spurious_d;
    logic            int_o_q, int_o_d;
    logic            vec_valid_q, vec_valid_d;

    logic            cand_found, top_found;
    logic [ID_W-1:0] cand_id, cand_rank, top_id, top_rank;
    logic [N-1:0]    isr_set, isr_clr;
    logic            seoi_hit;

    circ_priority_enc #(.N(N), .ID_W(ID_W)) u_cand_enc (
        .req   (irr & ~imr),
        .lp    (lp_q),
        .found (cand_found),
        .idx   (cand_id),
        .rank  (cand_rank)
    );

    circ_priority_enc #(.N(N), .ID_W(ID_W)) u_isr_enc (
        .req   (isr_q),
        .lp    (lp_q),
        .found (top_found),
        .idx   (top_id),
        .rank  (top_rank)
    );

    assign seoi_hit = seoi && (int'(seoi_id) < N);

    always_comb begin
        state_d     = state_q;
        lp_d        = lp_q;
        cur_id_d    = cur_id_q;
        spurious_d  = spurious_q;
        vec_id_d    = vec_id_q;
        irr_clr_d   = '0;
        vec_valid_d = 1'b0;
        isr_set     = '0;
        isr_clr     = '0;

        case (state_q)
            IDLE: begin
                if (inta_pulse) begin
                    state_d = WAIT2;
                    if (cand_found) begin
                        isr_set    = N'(1) << cand_id;
                        irr_clr_d  = N'(1) << cand_id;
                        cur_id_d   = cand_id;
                        spurious_d = 1'b0;
                    end else begin
                        cur_id_d   = LAST_ID;
                        spurious_d = 1'b1;
                    end
                end
            end
            WAIT2: begin
                if (inta_pulse) begin
                    state_d     = IDLE;
                    vec_valid_d = 1'b1;
                    vec_id_d    = cur_id_q;
                    if (aeoi_mode && !spurious_q) begin
                        isr_clr = N'(1) << cur_id_q;
                        if (rotate_mode) lp_d = cur_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An explicit EOI in the same cycle as an auto-EOI takes the final say on lp.
        if (seoi_hit) begin
            isr_clr = isr_clr | (N'(1) << seoi_id);
            if (rotate_mode) lp_d = seoi_id;
        end else if (eoi && !seoi && top_found) begin
            isr_clr = isr_clr | (N'(1) << top_id);
            if (rotate_mode) lp_d = top_id;
        end

        isr_d   = (isr_q & ~isr_clr) | isr_set;
        int_o_d = (state_d == IDLE) && cand_found && (!top_found || (cand_rank < top_rank));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            isr_q       <= '0;
            lp_q        <= LAST_ID;
            cur_id_q    <= '0;
            spurious_q  <= 1'b0;
            int_o_q     <= 1'b0;
            irr_clr_q   <= '0;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            isr_q       <= isr_d;
            lp_q        <= lp_d;
            cur_id_q    <= cur_id_d;
            spurious_q  <= spurious_d;
            int_o_q     <= int_o_d;
            irr_clr_q   <= irr_clr_d;
            vec_valid_q <= vec_valid_d;
            vec_id_q    <= vec_id_d;
        end
    end

    assign int_o     = int_o_q;
    assign isr       = isr_q;
    assign irr_clr   = irr_clr_q;
    assign vec_valid = vec_valid_q;
    assign vec_id    = vec_id_q;

endmodule
